// File: rtl/mc_control_unit_if.sv
// ---------------------------------------------------------------------------
// mc_control_unit_if
// Purpose : bundles the signals exchanged between the microcoded control unit
//           and the 16-bit multicycle datapath.
// Signals : instruction (datapath -> control), microPC, controls, is_halted,
//           num_inst (control -> datapath), cycle_count when the optional
//           cycle counter is built (macro MCU_CYCLE_COUNT_EN).
// Modports: master = control unit side, slave = datapath side.
// ---------------------------------------------------------------------------
interface mc_control_unit_if #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_WIDTH = 16
);
  logic [WORD_SIZE-1:0] instruction;
  logic [2:0]           microPC;
  logic [12:0]          controls;
  logic                 is_halted;
  logic [CNT_WIDTH-1:0] num_inst;
`ifdef MCU_CYCLE_COUNT_EN
  logic [31:0]          cycle_count;

  modport master (input instruction,
                  output microPC, controls, is_halted, num_inst, cycle_count);
  modport slave  (output instruction,
                  input microPC, controls, is_halted, num_inst, cycle_count);
`else
  modport master (input instruction,
                  output microPC, controls, is_halted, num_inst);
  modport slave  (output instruction,
                  input microPC, controls, is_halted, num_inst);
`endif
endinterface

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
// Purpose : microcoded sequencer for the 16-bit multicycle datapath. Steps
//           microPC through IF1/IF2/IF3/ID/EX/MEM1/MEM2/WB, one state per
//           clock, decodes the latched instruction into the 13-bit controls
//           bundle, detects HLT and counts committed instructions.
// Ports   : clk        - system clock, all state changes on posedge
//           reset      - synchronous, active-high reset
//           bus        - mc_control_unit_if.master (instruction in; microPC,
//                        controls, is_halted, num_inst out)
// Options : define MCU_CYCLE_COUNT_EN to add the 32-bit bus.cycle_count
//           counter of unhalted clocks since reset.
// controls: [12] WWD [11] Jump [10] Branch [9] MemtoReg [8] MemRead
//           [7] MemWrite [6] RegDst [5] RegWrite [4:1] ALUOp [0] ALUSrc
// ---------------------------------------------------------------------------
module mc_control_unit #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  mc_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    IF1 = 3'd0, IF2 = 3'd1, IF3 = 3'd2, ID = 3'd3,
    MEM1 = 3'd4, MEM2 = 3'd5, EX = 3'd6, WB = 3'd7
  } state_e;

  // Instruction classes: each class owns one micro-sequence after ID.
  typedef enum logic [2:0] {
    C_NOP, C_ALU, C_LWD, C_SWD, C_BR, C_JL, C_WWD, C_HLT
  } cls_e;

  localparam int B_WWD  = 12;
  localparam int B_JMP  = 11;
  localparam int B_BR   = 10;
  localparam int B_M2R  = 9;
  localparam int B_MRD  = 8;
  localparam int B_MWR  = 7;
  localparam int B_RDST = 6;
  localparam int B_RWR  = 5;
  localparam int B_SRC  = 0;

  logic [WORD_SIZE-1:0] instr;
  logic [3:0]           opcode;
  logic [5:0]           func;
  logic                 unused_instr_bits;

  state_e               state, state_nxt;
  cls_e                 cls;
  logic [12:0]          dec;
  logic [12:0]          controls;
  logic                 is_halted;
  logic [CNT_WIDTH-1:0] num_inst;
  logic                 halt_now;
  logic                 commit;

  assign instr             = bus.instruction;
  assign opcode            = instr[15:12];
  assign func              = instr[5:0];
  assign unused_instr_bits = ^instr[11:6];

  // Instruction decode: sequence class plus the ungated control pattern.
  // NOTE: every signal written in an always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    cls = C_NOP;
    dec = '0;
    case (opcode)
      4'd0, 4'd1, 4'd2, 4'd3: begin  // BNE/BEQ/BGZ/BLZ, ALUOp ADD
        cls        = C_BR;
        dec[B_BR]  = 1'b1;
        dec[B_SRC] = 1'b1;
      end
      4'd4: begin                    // ADI
        cls        = C_ALU;
        dec[B_SRC] = 1'b1;
      end
      4'd5: begin                    // ORI
        cls        = C_ALU;
        dec[4:1]   = 4'd3;
        dec[B_SRC] = 1'b1;
      end
      4'd6: begin                    // LHI
        cls        = C_ALU;
        dec[B_M2R] = 1'b1;
      end
      4'd7: begin                    // LWD
        cls        = C_LWD;
        dec[B_SRC] = 1'b1;
        dec[B_M2R] = 1'b1;
        dec[B_MRD] = 1'b1;
      end
      4'd8: begin                    // SWD
        cls        = C_SWD;
        dec[B_SRC] = 1'b1;
        dec[B_MWR] = 1'b1;
      end
      4'd9:  cls = C_BR;             // JMP
      4'd10: begin                   // JAL
        cls        = C_JL;
        dec[B_JMP] = 1'b1;
        dec[B_M2R] = 1'b1;
      end
      4'd15: begin
        if (func < 6'd8) begin       // R-type ALU
          cls         = C_ALU;
          dec[B_RDST] = 1'b1;
          dec[4:1]    = func[3:0];
        end else if (func == 6'd25) begin  // JPR
          cls = C_BR;
        end else if (func == 6'd26) begin  // JRL
          cls        = C_JL;
          dec[B_JMP] = 1'b1;
          dec[B_M2R] = 1'b1;
        end else if (func == 6'd28) begin  // WWD
          cls        = C_WWD;
          dec[B_WWD] = 1'b1;
        end else if (func == 6'd29) begin  // HLT
          cls = C_HLT;
        end
      end
      default: cls = C_NOP;          // 11-14 illegal, run as NOP
    endcase
  end

  // Next-state logic. A halted machine parks in ID until reset.
  always_comb begin
    state_nxt = IF1;
    if (is_halted) begin
      state_nxt = ID;
    end else begin
      case (state)
        IF1:  state_nxt = IF2;
        IF2:  state_nxt = IF3;
        IF3:  state_nxt = ID;
        ID:   state_nxt = (cls == C_HLT) ? ID :
                          (cls == C_NOP || cls == C_WWD) ? IF1 : EX;
        EX:   state_nxt = (cls == C_ALU || cls == C_JL) ? WB :
                          (cls == C_LWD || cls == C_SWD) ? MEM1 : IF1;
        MEM1: state_nxt = MEM2;
        MEM2: state_nxt = (cls == C_LWD) ? WB : IF1;
        WB:   state_nxt = IF1;
        default: state_nxt = IF1;
      endcase
    end
  end

  // HLT retires at its ID edge; every other instruction retires on the edge
  // that returns to IF1.
  assign halt_now = !is_halted && (state == ID) && (cls == C_HLT);
  assign commit   = !is_halted && (state_nxt == IF1);

  // Output decode: fetch states drive nothing, RegWrite is WB-only and the
  // memory strobes are confined to MEM1/MEM2.
  always_comb begin
    controls = '0;
    if (!is_halted && state != IF1 && state != IF2 && state != IF3) begin
      controls        = dec;
      controls[B_RWR] = (state == WB);
      controls[B_MRD] = dec[B_MRD] && (state == MEM1 || state == MEM2);
      controls[B_MWR] = dec[B_MWR] && (state == MEM1 || state == MEM2);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IF1;
      is_halted <= 1'b0;
      num_inst  <= '0;
    end else begin
      state <= state_nxt;
      if (halt_now) begin
        is_halted <= 1'b1;
      end
      if (commit || halt_now) begin
        num_inst <= num_inst + CNT_WIDTH'(1);
      end
    end
  end

`ifdef MCU_CYCLE_COUNT_EN
  logic [31:0] cycle_count;

  // The HLT edge itself is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (!is_halted && !halt_now) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  assign bus.cycle_count = cycle_count;
`endif

  assign bus.microPC   = state;
  assign bus.controls  = controls;
  assign bus.is_halted = is_halted;
  assign bus.num_inst  = num_inst;

endmodule

// File: tb/tb_mc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mc_control_unit
// Purpose : self-checking bench for mc_control_unit. A driver applies
//           directed and random instructions and pushes the expected
//           per-cycle outputs into a queue; a monitor pops and compares on
//           every falling clock edge.
// ---------------------------------------------------------------------------
module tb_mc_control_unit;

  typedef enum {
    K_RALU, K_ADI, K_ORI, K_LHI, K_LWD, K_SWD, K_BR, K_JMP, K_JAL,
    K_WWD, K_HLT, K_NOP
  } kind_e;

  typedef struct packed {
    logic       wwd, jump, branch, memtoreg, memread, memwrite, regdst, regwrite;
    logic [3:0] aluop;
    logic       alusrc;
  } ctrl_t;

  typedef struct {
    logic [2:0]  upc;
    logic [12:0] ctrl;
    logic        halted;
    logic [15:0] num;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  int   path_q[$];
  logic [15:0] num_m;
  logic [31:0] cyc_m;

  mc_control_unit_if #(.WORD_SIZE(16), .CNT_WIDTH(16)) bus ();

  mc_control_unit #(.WORD_SIZE(16), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---- reference model ----------------------------------------------------
  function automatic kind_e kind_of(input logic [15:0] ins);
    logic [3:0] op;
    logic [5:0] fn;
    op = ins[15:12];
    fn = ins[5:0];
    if (op <= 4'd3)  return K_BR;
    if (op == 4'd4)  return K_ADI;
    if (op == 4'd5)  return K_ORI;
    if (op == 4'd6)  return K_LHI;
    if (op == 4'd7)  return K_LWD;
    if (op == 4'd8)  return K_SWD;
    if (op == 4'd9)  return K_JMP;
    if (op == 4'd10) return K_JAL;
    if (op == 4'd15) begin
      if (fn <= 6'd7)  return K_RALU;
      if (fn == 6'd25) return K_JMP;
      if (fn == 6'd26) return K_JAL;
      if (fn == 6'd28) return K_WWD;
      if (fn == 6'd29) return K_HLT;
    end
    return K_NOP;
  endfunction

  // Micro-state walk of one instruction, fetch included.
  task automatic build_path(input logic [15:0] ins);
    kind_e k;
    k = kind_of(ins);
    path_q = {0, 1, 2, 3};
    case (k)
      K_RALU, K_ADI, K_ORI, K_LHI, K_JAL: path_q = {path_q, 6, 7};
      K_LWD:                              path_q = {path_q, 6, 4, 5, 7};
      K_SWD:                              path_q = {path_q, 6, 4, 5};
      K_BR, K_JMP:                        path_q = {path_q, 6};
      default: ;
    endcase
  endtask

  function automatic logic [12:0] ref_ctrl(input logic [15:0] ins, input int st);
    ctrl_t c;
    kind_e k;
    c = '0;
    k = kind_of(ins);
    if (st <= 2) return '0;
    case (k)
      K_RALU: begin c.regdst = 1'b1; c.aluop = ins[3:0]; end
      K_ADI:  c.alusrc = 1'b1;
      K_ORI:  begin c.aluop = 4'd3; c.alusrc = 1'b1; end
      K_LHI:  c.memtoreg = 1'b1;
      K_LWD:  begin c.alusrc = 1'b1; c.memtoreg = 1'b1; c.memread = (st == 4 || st == 5); end
      K_SWD:  begin c.alusrc = 1'b1; c.memwrite = (st == 4 || st == 5); end
      K_BR:   begin c.branch = 1'b1; c.alusrc = 1'b1; end
      K_JAL:  begin c.jump = 1'b1; c.memtoreg = 1'b1; end
      K_WWD:  c.wwd = 1'b1;
      default: ;
    endcase
    c.regwrite = (st == 7);
    return c;
  endfunction

  task automatic push_exp(input int st, input logic [12:0] ctrl, input logic halted,
                          input logic [15:0] num, input logic [31:0] cyc);
    exp_t e;
    e.upc = 3'(st);
    e.ctrl = ctrl;
    e.halted = halted;
    e.num = num;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // ---- monitor ------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("microPC",   32'(bus.microPC),   32'(e.upc));
        check("controls",  32'(bus.controls),  32'(e.ctrl));
        check("is_halted", 32'(bus.is_halted), 32'(e.halted));
        check("num_inst",  32'(bus.num_inst),  32'(e.num));
`ifdef MCU_CYCLE_COUNT_EN
        check("cycle_count", bus.cycle_count, e.cyc);
`endif
      end
    end
  end

  // ---- driver -------------------------------------------------------------
  // Entered just after the posedge that lands in IF1. abort_at > 0 asserts
  // reset while the abort_at-th micro-state is current.
  task automatic run_instr(input logic [15:0] ins, input int abort_at);
    int n;
    bus.instruction = ins;
    build_path(ins);
    n = (abort_at > 0) ? abort_at : path_q.size();
    for (int i = 0; i < n; i++) begin
      push_exp(path_q[i], ref_ctrl(ins, path_q[i]), 1'b0, num_m, cyc_m);
      cyc_m++;
    end
    if (abort_at > 0) begin
      repeat (n - 1) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      num_m = '0;
      cyc_m = '0;
    end else begin
      repeat (n) @(posedge clk);
      #1;
      num_m++;
    end
  endtask

  task automatic run_halt(input int hold);
    bus.instruction = 16'hF01D;
    for (int i = 0; i < 4; i++) push_exp(i, '0, 1'b0, num_m, cyc_m + 32'(i));
    cyc_m += 32'd3;
    num_m++;
    for (int i = 0; i < hold; i++) push_exp(3, '0, 1'b1, num_m, cyc_m);
    repeat (4) @(posedge clk);
    #1;
    repeat (hold) begin
      bus.instruction = 16'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    num_m = '0;
    cyc_m = '0;
  endtask

  initial begin
    logic [15:0] ins;
    reset = 1'b1;
    bus.instruction = '0;
    num_m = '0;
    cyc_m = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_instr(16'hF000, 0);   // ADD
    run_instr(16'h7100, 0);   // LWD
    run_instr(16'h8000, 0);   // SWD
    run_instr(16'h1000, 0);   // BEQ
    run_instr(16'hF01C, 0);   // WWD
    run_instr(16'hA000, 0);   // JAL
    run_instr(16'h5000, 0);   // ORI
    run_instr(16'hF01A, 0);   // JRL

    do_reset();
    run_instr(16'hB000, 0);   // illegal opcode
    run_instr(16'hF005, 0);   // R-ALU func 5

    run_instr(16'h7100, 6);   // reset lands while LWD sits in MEM1
    run_instr(16'hF000, 0);

    for (int i = 0; i < 120; i++) begin
      ins = 16'($urandom);
      if (ins[15:12] == 4'd15 && ins[5:0] == 6'd29) ins[0] = 1'b0;
      run_instr(ins, 0);
    end

    run_halt(20);
    do_reset();
    run_instr(16'hF003, 0);

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Microcoded sequencer for the 16-bit multicycle datapath.
- Advances microPC through the fetch, decode, execute, memory and writeback states, one state per clock.
- Decodes the latched instruction into the 13-bit controls bundle the datapath consumes.
- Detects HLT, raises is_halted, and counts committed instructions.

Parameters:
- WORD_SIZE, 16, instruction/data width.
- CNT_WIDTH, 16, width of num_inst counter.

Ports:
- clk  input  1  system clock, all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- instruction  input  WORD_SIZE  instruction register from datapath; valid from ID onward.
- microPC  output  3  current micro-state.
- controls  output  13  datapath control bundle.
- is_halted  output  1  high once HLT has decoded; freezes datapath.
- num_inst  output  CNT_WIDTH  committed instruction count.

Behaviour:
- State encoding: IF1=0, IF2=1, IF3=2, ID=3, MEM1=4, MEM2=5, EX=6, WB=7.
- Reset (reset=1 at posedge): microPC=IF1, is_halted=0, num_inst=0. Reset overrides everything, including mid-instruction and halted states. controls=0 while in IF1.
- Fetch is always IF1 -> IF2 -> IF3 -> ID.
- Sequences after ID, by opcode instruction[15:12] / func instruction[5:0]:
  - R-ALU (op 15, func 0-7), ADI(4), ORI(5), LHI(6): EX -> WB -> IF1 (6 cycles).
  - LWD(7): EX -> MEM1 -> MEM2 -> WB -> IF1 (8 cycles).
  - SWD(8): EX -> MEM1 -> MEM2 -> IF1 (7 cycles).
  - BNE(0), BEQ(1), BGZ(2), BLZ(3), JMP(9), JPR(func 25): EX -> IF1 (5 cycles).
  - JAL(10), JRL(func 26): EX -> WB -> IF1 (6 cycles).
  - WWD(func 28): ID -> IF1 (4 cycles).
  - HLT(func 29): at the ID posedge, is_halted<=1 and microPC stays ID permanently until reset.
  - Illegal opcode 11-14 or undefined func: treated as NOP, ID -> IF1.
- controls bit map:
  - [12] WWD, [11] Jump, [10] Branch, [9] MemtoReg, [8] MemRead, [7] MemWrite.
  - [6] RegDst, [5] RegWrite, [4:1] ALUOp, [0] ALUSrc.
- controls timing:
  - All 13 bits are 0 in IF1, IF2 and IF3.
  - In ID..last state, controls are a combinational decode of instruction.
  - RegWrite is 1 only in WB.
  - MemRead/MemWrite are 1 only in MEM1/MEM2.
- Decode values:
  - R-ALU: RegDst=1, ALUOp=func[3:0], ALUSrc=0.
  - ADI: ALUOp=0(ADD), ALUSrc=1.
  - ORI: ALUOp=3(ORR), ALUSrc=1.
  - LHI: MemtoReg=1.
  - LWD: ALUOp=0, ALUSrc=1, MemRead, MemtoReg=1.
  - SWD: ALUOp=0, ALUSrc=1, MemWrite.
  - Branches: Branch=1, ALUOp=0, ALUSrc=1.
  - JAL/JRL: Jump=1, MemtoReg=1, RegDst=0.
  - WWD: WWD=1.
  - All other bits 0.
- num_inst:
  - Increments by 1 on the posedge that moves the final state of an instruction back to IF1.
  - The HLT posedge also counts, exactly once.
  - Wraps modulo 2^CNT_WIDTH.
- Halted: microPC, controls, and num_inst are frozen. instruction changes are ignored.

Optional Feature:
- Macro MCU_CYCLE_COUNT_EN.
- Defined:
  - Adds output cycle_count (32-bit).
  - Reset to 0; increments every non-reset posedge while is_halted=0.
  - Stops incrementing from the posedge that sets is_halted.
  - Wraps at 2^32.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then feed ADD (0xF000 | func 0): microPC 0,1,2,3,6,7,0. controls=0 during 0-2. RegWrite=1 and RegDst=1 only at WB. num_inst=1 after 6 cycles.
- LWD 0x7100: microPC 0,1,2,3,6,4,5,7,0. MemRead=1 only in states 4 and 5. MemtoReg=1, ALUSrc=1. num_inst increments at the 8th edge.
- SWD then BEQ then WWD back to back: SWD takes 7 cycles, BEQ 5 (Branch=1 in EX), WWD 4 (WWD=1 in ID). num_inst=3 after 16 cycles.
- HLT 0xF01D: is_halted=1 after ID edge; microPC stays 3 for 20 further cycles; num_inst +1 only once. Then reset=1 gives microPC=0, is_halted=0, num_inst=0.
- Assert reset while in MEM1 of LWD: next edge microPC=0, controls=0, num_inst=0, no WB occurs.
- Opcode 0xB000 (illegal): 4 cycles, ID -> IF1, all controls 0, num_inst +1. With MCU_CYCLE_COUNT_EN: cycle_count=4 at completion.
